// File: rtl/stack_ctrl_pkg.sv
// Shared encodings and default bounds for the MiniRISC stack sequencer.
package stack_ctrl_pkg;

    localparam logic [7:0] DEF_STACK_BASE  = 8'd127;
    localparam logic [7:0] DEF_STACK_LIMIT = 8'd64;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_t;

    typedef enum logic [3:0] {
        S_IDLE, S_CHK, S_WR0, S_WR1, S_RD0, S_RD1, S_UPD, S_FIN, S_ERR
    } state_t;

    localparam logic ERR_OVF = 1'b0;
    localparam logic ERR_UDF = 1'b1;

endpackage

// File: rtl/stack_ctrl_if.sv
// Command, register-file and data-memory signals between the CPU side and the stack sequencer.
interface stack_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] push_data;
    logic [7:0] pc_in;
    logic [3:0] flags_in;
    logic [7:0] sp_in;
    logic       busy;
    logic       done;
    logic       err;
    logic       err_code;
    logic [7:0] pop_data;
    logic [7:0] ret_pc;
    logic [3:0] ret_flags;
    logic       sp_wr_en;
    logic [7:0] sp_wr_data;
    logic [7:0] dmem_addr;
    logic       dmem_wr;
    logic       dmem_rd;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;
    logic       dmem_ack;

    modport master (
        output cmd_valid, cmd_op, push_data, pc_in, flags_in, sp_in, dmem_rdata, dmem_ack,
        input  busy, done, err, err_code, pop_data, ret_pc, ret_flags,
               sp_wr_en, sp_wr_data, dmem_addr, dmem_wr, dmem_rd, dmem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, push_data, pc_in, flags_in, sp_in, dmem_rdata, dmem_ack,
        output busy, done, err, err_code, pop_data, ret_pc, ret_flags,
               sp_wr_en, sp_wr_data, dmem_addr, dmem_wr, dmem_rd, dmem_wdata
    );
endinterface

// File: rtl/stack_ctrl.sv
// Multi-cycle PUSH/POP/CALL/RET sequencer; 5 cycles (PUSH/POP) or 6 (CALL/RET) accept-to-done with
// zero-wait memory, +1 per memory wait cycle; requests held until dmem_ack, CPU stalls on busy.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter logic [7:0] STACK_BASE  = DEF_STACK_BASE,
    parameter logic [7:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
    input  logic         clk,
    input  logic         rst,
    stack_ctrl_if.slave  bus
);

    state_t     r_state;
    op_t        r_op;
    logic [7:0] r_sp, r_push, r_pc;
    logic [3:0] r_flags;
    logic [7:0] r_rd0, r_rd1;
    logic       r_busy, r_done, r_err, r_err_code;
    logic [7:0] r_pop_data, r_ret_pc;
    logic [3:0] r_ret_flags;
    logic       r_sp_wr_en;
    logic [7:0] r_sp_wr_data;
    logic [7:0] r_dmem_addr, r_dmem_wdata;
    logic       r_dmem_wr, r_dmem_rd;

    logic       w_fail, w_code;
    logic [7:0] w_sp_new;

    // Bounds are checked on the latched SP so no 8-bit update can wrap.
    always_comb begin
        w_fail   = 1'b0;
        w_code   = ERR_OVF;
        w_sp_new = r_sp;
        unique case (r_op)
            OP_PUSH: begin
                w_fail   = (r_sp < STACK_LIMIT);
                w_sp_new = r_sp - 8'd1;
            end
            OP_CALL: begin
                w_fail   = (r_sp < STACK_LIMIT + 8'd1);
                w_sp_new = r_sp - 8'd2;
            end
            OP_POP: begin
                w_fail   = (r_sp > STACK_BASE - 8'd1);
                w_code   = ERR_UDF;
                w_sp_new = r_sp + 8'd1;
            end
            OP_RET: begin
                w_fail   = (r_sp > STACK_BASE - 8'd2);
                w_code   = ERR_UDF;
                w_sp_new = r_sp + 8'd2;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= OP_PUSH;
            r_sp         <= '0;
            r_push       <= '0;
            r_pc         <= '0;
            r_flags      <= '0;
            r_rd0        <= '0;
            r_rd1        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 1'b0;
            r_pop_data   <= '0;
            r_ret_pc     <= '0;
            r_ret_flags  <= '0;
            r_sp_wr_en   <= 1'b0;
            r_sp_wr_data <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_wr    <= 1'b0;
            r_dmem_rd    <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_sp_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.cmd_valid) begin
                    r_op    <= op_t'(bus.cmd_op);
                    r_sp    <= bus.sp_in;
                    r_push  <= bus.push_data;
                    r_pc    <= bus.pc_in;
                    r_flags <= bus.flags_in;
                    r_busy  <= 1'b1;
                    r_state <= S_CHK;
                end
                S_CHK: begin
                    if (w_fail) begin
                        r_err      <= 1'b1;
                        r_err_code <= w_code;
                        r_state    <= S_ERR;
                    end else if (r_op == OP_PUSH || r_op == OP_CALL) begin
                        r_dmem_wr    <= 1'b1;
                        r_dmem_addr  <= r_sp;
                        r_dmem_wdata <= (r_op == OP_PUSH) ? r_push : r_pc;
                        r_state      <= S_WR0;
                    end else begin
                        r_dmem_rd   <= 1'b1;
                        r_dmem_addr <= r_sp + 8'd1;
                        r_state     <= S_RD0;
                    end
                end
                S_WR0: if (bus.dmem_ack) begin
                    if (r_op == OP_CALL) begin
                        r_dmem_addr  <= r_sp - 8'd1;
                        r_dmem_wdata <= {4'b0, r_flags};
                        r_state      <= S_WR1;
                    end else begin
                        r_dmem_wr    <= 1'b0;
                        r_sp_wr_en   <= 1'b1;
                        r_sp_wr_data <= w_sp_new;
                        r_state      <= S_UPD;
                    end
                end
                S_WR1: if (bus.dmem_ack) begin
                    r_dmem_wr    <= 1'b0;
                    r_sp_wr_en   <= 1'b1;
                    r_sp_wr_data <= w_sp_new;
                    r_state      <= S_UPD;
                end
                S_RD0: if (bus.dmem_ack) begin
                    r_rd0 <= bus.dmem_rdata;
                    if (r_op == OP_RET) begin
                        r_dmem_addr <= r_sp + 8'd2;
                        r_state     <= S_RD1;
                    end else begin
                        r_dmem_rd    <= 1'b0;
                        r_sp_wr_en   <= 1'b1;
                        r_sp_wr_data <= w_sp_new;
                        r_state      <= S_UPD;
                    end
                end
                S_RD1: if (bus.dmem_ack) begin
                    r_rd1        <= bus.dmem_rdata;
                    r_dmem_rd    <= 1'b0;
                    r_sp_wr_en   <= 1'b1;
                    r_sp_wr_data <= w_sp_new;
                    r_state      <= S_UPD;
                end
                // Results become visible together with done, so aborted ops never disturb them.
                S_UPD: begin
                    if (r_op == OP_POP) r_pop_data <= r_rd0;
                    if (r_op == OP_RET) begin
                        r_ret_flags <= r_rd0[3:0];
                        r_ret_pc    <= r_rd1;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_FIN;
                end
                S_FIN, S_ERR: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;
    assign bus.pop_data   = r_pop_data;
    assign bus.ret_pc     = r_ret_pc;
    assign bus.ret_flags  = r_ret_flags;
    assign bus.sp_wr_en   = r_sp_wr_en;
    assign bus.sp_wr_data = r_sp_wr_data;
    assign bus.dmem_addr  = r_dmem_addr;
    assign bus.dmem_wr    = r_dmem_wr;
    assign bus.dmem_rd    = r_dmem_rd;
    assign bus.dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: fixed vectors, a reset-abort sequence and random ops against a stack model.
module tb_stack_ctrl;
    import stack_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    stack_ctrl_if bus();

    stack_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] sp, pd, pc;
        logic [3:0] fl;
        int         waits;
        logic       e_err, e_code;
        logic [7:0] e_sp;
        int         e_lat;
        logic [7:0] e_r8;
        logic [3:0] e_r4;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  tb_mem  [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  m_pop, m_pc;
    logic [3:0]  m_fl;
    logic [16:0] obs_q[$];
    int          wcnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after `waits` stalled cycles and logs each completed access.
    task automatic mem_step(input int waits);
        if (bus.dmem_wr || bus.dmem_rd) begin
            if (wcnt >= waits) begin
                bus.dmem_ack = 1'b1;
                if (bus.dmem_wr) begin
                    tb_mem[bus.dmem_addr] = bus.dmem_wdata;
                    obs_q.push_back({1'b1, bus.dmem_addr, bus.dmem_wdata});
                end else begin
                    bus.dmem_rdata = tb_mem[bus.dmem_addr];
                    obs_q.push_back({1'b0, bus.dmem_addr, tb_mem[bus.dmem_addr]});
                end
                wcnt = 0;
            end else begin
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = 8'($urandom);
                wcnt++;
            end
        end else begin
            bus.dmem_ack = 1'b0;
            wcnt = 0;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] sp, pd, pc, input logic [3:0] fl,
                          input int waits, input bit noise,
                          output int lat, output logic g_err, g_code, output logic [7:0] g_sp);
        logic [16:0] exp_q[$];
        bit          ok, fin;
        int          cyc, spwr_cnt, done_cnt, err_cnt, req_cyc, hold_bad, busy_bad;
        logic [17:0] prev_sig;
        bit          prev_req, prev_ack;
        logic [7:0]  nsp;

        // Reference: stack rules applied to the model memory.
        exp_q = {};
        case (op)
            2'b00: begin ok = (sp >= 8'd64);  exp_q.push_back({1'b1, sp, pd}); nsp = sp - 8'd1; end
            2'b10: begin ok = (sp >= 8'd65);  exp_q.push_back({1'b1, sp, pc});
                         exp_q.push_back({1'b1, sp - 8'd1, 4'b0, fl}); nsp = sp - 8'd2; end
            2'b01: begin ok = (sp <= 8'd126); exp_q.push_back({1'b0, sp + 8'd1, ref_mem[sp + 8'd1]});
                         nsp = sp + 8'd1; end
            default: begin ok = (sp <= 8'd125); exp_q.push_back({1'b0, sp + 8'd1, ref_mem[sp + 8'd1]});
                         exp_q.push_back({1'b0, sp + 8'd2, ref_mem[sp + 8'd2]}); nsp = sp + 8'd2; end
        endcase
        if (!ok) exp_q = {};

        obs_q = {};
        lat = 0; g_err = 1'b0; g_code = 1'b0; g_sp = 8'h00;
        spwr_cnt = 0; done_cnt = 0; err_cnt = 0; req_cyc = 0; hold_bad = 0; busy_bad = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_sig = '0;
        fin = 1'b0;

        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.sp_in = sp;
        bus.push_data = pd; bus.pc_in = pc; bus.flags_in = fl;
        cyc = 1;
        while (!fin && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done) begin done_cnt++; lat = cyc; fin = 1'b1; end
            if (bus.err)  begin err_cnt++;  lat = cyc; g_err = 1'b1; g_code = bus.err_code; fin = 1'b1; end
            if (bus.sp_wr_en) begin spwr_cnt++; g_sp = bus.sp_wr_data; end
            if (bus.dmem_wr || bus.dmem_rd) begin
                req_cyc++;
                if (prev_req && !prev_ack &&
                    prev_sig != {bus.dmem_wr, bus.dmem_rd, bus.dmem_addr, bus.dmem_wdata}) hold_bad++;
            end
            prev_req = bus.dmem_wr || bus.dmem_rd;
            prev_sig = {bus.dmem_wr, bus.dmem_rd, bus.dmem_addr, bus.dmem_wdata};
            mem_step(waits);
            prev_ack = bus.dmem_ack;
            if (!fin && noise) begin
                bus.cmd_valid = 1'($urandom);
                bus.cmd_op    = 2'($urandom);
                bus.sp_in     = 8'($urandom);
                bus.push_data = 8'($urandom);
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end
        check("op_timeout", fin, 1'b1);
        @(negedge clk);
        mem_step(waits);
        check("idle_after_op", {bus.busy, bus.done, bus.err, bus.sp_wr_en, bus.dmem_wr, bus.dmem_rd}, 6'b0);

        if (ok) begin
            foreach (exp_q[i]) if (exp_q[i][16]) ref_mem[exp_q[i][15:8]] = exp_q[i][7:0];
            if (op == 2'b01) m_pop = exp_q[0][7:0];
            if (op == 2'b11) begin m_fl = exp_q[0][3:0]; m_pc = exp_q[1][7:0]; end
        end
        check("err_pulse", err_cnt, ok ? 0 : 1);
        check("done_pulse", done_cnt, ok ? 1 : 0);
        check("sp_wr_en_count", spwr_cnt, ok ? 1 : 0);
        if (ok) check("sp_wr_data", g_sp, nsp);
        else    check("err_code", g_code, (op == 2'b00 || op == 2'b10) ? ERR_OVF : ERR_UDF);
        check("latency", lat, ok ? 4 + exp_q.size() * (1 + waits) : 3);
        check("access_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check("access", obs_q[i], exp_q[i]);
        check("req_cycles", req_cyc, exp_q.size() * (1 + waits));
        check("req_stable", hold_bad, 0);
        check("busy_during_op", busy_bad, 0);
        check("held_results", {bus.pop_data, bus.ret_pc, bus.ret_flags}, {m_pop, m_pc, m_fl});
    endtask

    vec_t        tbl[12];
    int          lat;
    logic        g_err, g_code;
    logic [7:0]  g_sp;
    logic [7:0]  rsp;
    int          bad;

    initial begin
        tbl[0]  = '{2'b00, 8'd127, 8'hA5, 8'h00, 4'h0, 0, 1'b0, 1'b0, 8'd126, 5, 8'h00, 4'h0};
        tbl[1]  = '{2'b10, 8'd126, 8'h00, 8'h3C, 4'hA, 0, 1'b0, 1'b0, 8'd124, 6, 8'h00, 4'h0};
        tbl[2]  = '{2'b11, 8'd124, 8'h00, 8'h00, 4'h0, 0, 1'b0, 1'b0, 8'd126, 6, 8'h3C, 4'hA};
        tbl[3]  = '{2'b01, 8'd127, 8'h00, 8'h00, 4'h0, 0, 1'b1, 1'b1, 8'd0,   3, 8'h00, 4'h0};
        tbl[4]  = '{2'b00, 8'd63,  8'h77, 8'h00, 4'h0, 0, 1'b1, 1'b0, 8'd0,   3, 8'h00, 4'h0};
        tbl[5]  = '{2'b10, 8'd64,  8'h00, 8'h44, 4'h1, 0, 1'b1, 1'b0, 8'd0,   3, 8'h00, 4'h0};
        tbl[6]  = '{2'b10, 8'd65,  8'h00, 8'h11, 4'h5, 0, 1'b0, 1'b0, 8'd63,  6, 8'h00, 4'h0};
        tbl[7]  = '{2'b00, 8'd127, 8'h5E, 8'h00, 4'h0, 0, 1'b0, 1'b0, 8'd126, 5, 8'h00, 4'h0};
        tbl[8]  = '{2'b01, 8'd126, 8'h00, 8'h00, 4'h0, 3, 1'b0, 1'b0, 8'd127, 8, 8'h5E, 4'h0};
        tbl[9]  = '{2'b11, 8'd126, 8'h00, 8'h00, 4'h0, 0, 1'b1, 1'b1, 8'd0,   3, 8'h00, 4'h0};
        tbl[10] = '{2'b00, 8'd64,  8'h33, 8'h00, 4'h0, 0, 1'b0, 1'b0, 8'd63,  5, 8'h00, 4'h0};
        tbl[11] = '{2'b11, 8'd125, 8'h00, 8'h00, 4'h0, 1, 1'b0, 1'b0, 8'd127, 8, 8'h5E, 4'hC};

        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        m_pop = 8'h00; m_pc = 8'h00; m_fl = 4'h0;
        wcnt = 0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.push_data = 8'h00; bus.pc_in = 8'h00;
        bus.flags_in = 4'h0; bus.sp_in = 8'h00; bus.dmem_rdata = 8'h00; bus.dmem_ack = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {bus.busy, bus.done, bus.err, bus.err_code, bus.pop_data, bus.ret_pc,
                              bus.ret_flags, bus.sp_wr_en, bus.sp_wr_data, bus.dmem_addr, bus.dmem_wr,
                              bus.dmem_rd, bus.dmem_wdata}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].sp, tbl[i].pd, tbl[i].pc, tbl[i].fl, tbl[i].waits, 1'b0,
                   lat, g_err, g_code, g_sp);
            check($sformatf("tbl%0d_err", i), g_err, tbl[i].e_err);
            check($sformatf("tbl%0d_lat", i), lat, tbl[i].e_lat);
            if (tbl[i].e_err) check($sformatf("tbl%0d_code", i), g_code, tbl[i].e_code);
            else              check($sformatf("tbl%0d_sp", i), g_sp, tbl[i].e_sp);
            if (!tbl[i].e_err && tbl[i].op == 2'b01) check($sformatf("tbl%0d_pop", i), bus.pop_data, tbl[i].e_r8);
            if (!tbl[i].e_err && tbl[i].op == 2'b11)
                check($sformatf("tbl%0d_ret", i), {bus.ret_pc, bus.ret_flags}, {tbl[i].e_r8, tbl[i].e_r4});
        end

        // Reset while the second CALL write is pending; busy-time cmd_valid pulses must be ignored.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.sp_in = 8'd100; bus.pc_in = 8'h77; bus.flags_in = 4'h3;
        bad = 0;
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 30 && !hit; c++) begin
                @(negedge clk);
                if (bus.done || bus.sp_wr_en || bus.err) bad++;
                if (bus.dmem_wr && bus.dmem_addr == 8'd99) begin
                    hit = 1'b1;
                    bus.dmem_ack = 1'b0;
                    rst = 1'b1;
                end else begin
                    mem_step(1);
                    bus.cmd_valid = 1'($urandom);
                    bus.cmd_op    = 2'($urandom);
                end
            end
            bus.cmd_valid = 1'b0;
            check("reset_abort_reached_wr1", hit, 1'b1);
        end
        @(negedge clk);
        rst = 1'b0;
        check("reset_abort_outputs", {bus.busy, bus.done, bus.err, bus.err_code, bus.pop_data, bus.ret_pc,
                                      bus.ret_flags, bus.sp_wr_en, bus.sp_wr_data, bus.dmem_addr,
                                      bus.dmem_wr, bus.dmem_rd, bus.dmem_wdata}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            mem_step(0);
            if (bus.done || bus.sp_wr_en || bus.busy || bus.dmem_wr) bad++;
        end
        check("reset_abort_quiet", bad, 0);
        ref_mem[100] = 8'h77;
        m_pop = 8'h00; m_pc = 8'h00; m_fl = 4'h0;

        for (int i = 0; i < 150; i++) begin
            rsp = 8'($urandom_range(56, 135));
            run_op(2'($urandom), rsp, 8'($urandom), 8'($urandom), 4'($urandom), $urandom_range(0, 3), 1'b1,
                   lat, g_err, g_code, g_sp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
